// File: rtl/systolic_result_drain_if.sv
// Result beat stream from systolic_result_drain to the downstream result bus/DMA.
// The master drives a beat and the slave accepts it with out_ready.
interface systolic_result_drain_if #(
  parameter int OUT_W = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [2:0]       out_idx;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures NUM_ROWS row results on done_in and streams them out as OUT_W beats.
// Define SYSTOLIC_DRAIN_REQUANT_EN to requantise each row by layer_scale into one beat per row.
module systolic_result_drain #(
  parameter int NUM_ROWS   = 4,
  parameter int RES_W      = 64,
  parameter int OUT_W      = 32,
  parameter int SCALE_FRAC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      done_in,
  input  logic [NUM_ROWS*RES_W-1:0] res_flat,
  input  logic [31:0]               layer_scale,
  input  logic                      clr_overrun,
  systolic_result_drain_if.master   out_if,
  output logic                      busy,
  output logic                      overrun
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALE  = 2'd1,
    STREAM = 2'd2
  } state_t;

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
  localparam int     BEATS      = NUM_ROWS;
  localparam state_t TILE_ENTRY = SCALE;
`else
  localparam int     BEATS      = 2 * NUM_ROWS;
  localparam state_t TILE_ENTRY = STREAM;
`endif
  localparam logic [2:0] LAST_IDX = 3'(BEATS - 1);

  state_t           state_q, state_d;
  logic [RES_W-1:0] cap_q [NUM_ROWS];
  logic [2:0]       idx_q;
  logic             overrun_q;
  logic             xfer;
  logic             last_beat;
  logic             accept;
  logic [OUT_W-1:0] beat_data;

  assign xfer      = (state_q == STREAM) && out_if.out_ready;
  assign last_beat = (idx_q == LAST_IDX);
  // A new tile is taken when idle or exactly as the last beat of the current one leaves.
  assign accept    = done_in && ((state_q == IDLE) || (xfer && last_beat));

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
  localparam int PROD_W = RES_W + 32;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(64'sd2147483647);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-64'sd2147483648);
  localparam logic signed [PROD_W-1:0] ROUND   = PROD_W'(1) << (SCALE_FRAC - 1);

  logic [ROW_W-1:0]         row_q;
  logic [31:0]              scale_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W-1:0] shifted;
  logic [OUT_W-1:0]         sat;

  // Sign-extended operands make the low PROD_W bits of the product the signed result.
  always_comb begin
    prod    = {{(PROD_W-RES_W){cap_q[row_q][RES_W-1]}}, cap_q[row_q]}
            * {{(PROD_W-32){scale_q[31]}}, scale_q};
    rounded = prod + ROUND;
    shifted = rounded >>> SCALE_FRAC;
    if (shifted > SAT_MAX) begin
      sat = OUT_W'(32'h7FFF_FFFF);
    end else if (shifted < SAT_MIN) begin
      sat = OUT_W'(32'h8000_0000);
    end else begin
      sat = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      scale_q <= '0;
    end else if (accept) begin
      row_q   <= '0;
      scale_q <= layer_scale;
    end else if (state_q == SCALE) begin
      row_q   <= ROW_W'(row_q + 1'b1);
    end
  end
`else
  logic unused_scale;
  localparam int unused_frac = SCALE_FRAC;
  assign unused_scale = ^layer_scale;
`endif

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (done_in) state_d = TILE_ENTRY;
      end
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
      SCALE: begin
        if (row_q == ROW_W'(NUM_ROWS - 1)) state_d = STREAM;
      end
`endif
      STREAM: begin
        if (xfer && last_beat) state_d = done_in ? TILE_ENTRY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= '0;
      end else if (xfer) begin
        idx_q <= last_beat ? 3'd0 : 3'(idx_q + 3'd1);
      end
      if (done_in && !accept) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // NOTE: the capture buffer is reset explicitly so out_data reads 0 before the first tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) cap_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_ROWS; i++) cap_q[i] <= res_flat[i*RES_W +: RES_W];
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
    end else if (state_q == SCALE) begin
      cap_q[row_q][OUT_W-1:0] <= sat;
`endif
    end
  end

  always_comb begin
    beat_data = '0;
    if (state_q == STREAM) begin
`ifdef SYSTOLIC_DRAIN_REQUANT_EN
      beat_data = cap_q[idx_q[ROW_W-1:0]][OUT_W-1:0];
`else
      beat_data = idx_q[0] ? cap_q[idx_q[ROW_W:1]][RES_W-1:OUT_W]
                           : cap_q[idx_q[ROW_W:1]][OUT_W-1:0];
`endif
    end
  end

  assign out_if.out_valid = (state_q == STREAM);
  assign out_if.out_data  = beat_data;
  assign out_if.out_idx   = idx_q;
  assign out_if.out_last  = (state_q == STREAM) && last_beat;
  assign busy             = (state_q != IDLE);
  assign overrun          = overrun_q;

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Consumer-side counterpart of the weight/activation write port: captures the four 64-bit row results from the systolic array on its done pulse and streams them out as 32-bit beats over a valid/ready interface.
- Sits between the systolic top level and the downstream result bus/DMA.
- Frees the array for the next tile while the previous results drain.

Parameters:
- NUM_ROWS, 4, number of row results captured per done pulse.
- RES_W, 64, width of each row result (signed).
- OUT_W, 32, output beat width.
- SCALE_FRAC, 16, fractional bits of layer_scale (Q16.16); used only in requant mode.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- done_in  input  1  single-cycle pulse: res_flat valid this cycle.
- res_flat  input  NUM_ROWS*RES_W  row results; Re1 in bits [63:0], Re2 in [127:64], Re3 in [191:128], Re4 in [255:192].
- layer_scale  input  32  signed Q16.16 requant scale; sampled with done_in.
- clr_overrun  input  1  clears the overrun flag.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_W  beat payload.
- out_idx  output  3  beat index within the tile, starting at 0.
- out_last  output  1  final beat of the tile.
- busy  output  1  high when state != IDLE.
- overrun  output  1  sticky: done_in arrived while busy.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overrun=0; capture buffer cleared. Reset mid-stream abandons the tile with no further beats.
- States: IDLE, SCALE (requant build only), STREAM.
- IDLE + done_in: register res_flat into the capture buffer and register layer_scale.
  - Raw build: go to STREAM.
  - Requant build: go to SCALE.
- Raw build:
  - Beats per tile = 2*NUM_ROWS = 8, order Re1.lo, Re1.hi, Re2.lo, ... Re4.hi.
  - out_valid rises the cycle after done_in.
- STREAM:
  - out_valid=1.
  - A beat transfers on any edge where out_valid and out_ready are both high. out_idx then increments.
  - out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0.
  - out_last=1 only while out_idx = beats-1.
  - Transfer of the last beat returns the FSM to IDLE and drops out_valid the next cycle, unless done_in is also high that cycle (see below).
- done_in coinciding with the last-beat transfer:
  - The new tile is captured; no overrun.
  - Raw build: the FSM stays in STREAM with out_idx=0, giving back-to-back tiles with no bubble.
  - Requant build: the FSM enters SCALE.
- done_in at any other time while busy: ignored, the buffer is untouched, and overrun is set.
  - overrun clears only on clr_overrun=1 (or reset).
  - Simultaneous set and clr_overrun: set wins.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_REQUANT_EN.
- Defined:
  - SCALE processes one row per cycle for NUM_ROWS cycles.
  - Per row: product = signed Re(64) * signed layer_scale(32), computed at 96 bits.
  - Add 2^(SCALE_FRAC-1) for round-half-up, then arithmetic shift right by SCALE_FRAC.
  - Saturate to [-2^31, 2^31-1] and store back into the row's low word.
  - Beats per tile = NUM_ROWS = 4, order Re1..Re4.
  - out_valid rises NUM_ROWS+1 = 5 cycles after done_in.
- Undefined: raw 8-beat mode; layer_scale is ignored and no multiplier is synthesised.

Test Plan:
- Raw readout: done_in with Re1=64'h0000_0001_0000_0002, Re2..Re4 = 3, 4, 5, out_ready held 1.
  - Required: out_valid rises 1 cycle later.
  - Beats: 2, 1, 3, 0, 4, 0, 5, 0.
  - out_last only on idx 7; busy falls after the 8th transfer.
- Backpressure: same tile with out_ready toggled 1,0,0,1,... .
  - Required: data/idx held during stalls, no beat lost or duplicated, 8 transfers total.
- Overrun: second done_in at idx 3.
  - Required: overrun=1; remaining beats still come from the first tile.
  - clr_overrun pulse -> overrun=0.
- Simultaneous: done_in in the same cycle as the last-beat transfer (raw build).
  - Required: next tile's idx 0 is valid the following cycle, with no idle gap and overrun=0.
- Requant (macro defined): layer_scale=32'h0000_8000 (0.5) with Re1=7, Re2=-7, Re3=64'h7FFF_FFFF_FFFF_FFFF, Re4=-2^40.
  - Required beats: 4, -3, 32'h7FFF_FFFF, 32'h8000_0000.
  - First valid 5 cycles after done_in.
- Reset mid-stream: assert rst_n=0 at beat 2.
  - Required: all outputs 0 immediately.
  - After release, no beats appear until a new done_in.
